picorv32_ddr3_bridge: RTL

- Parametrised bridge between the picorv32 native memory bus and the Avalon-MM user port of the DDR3 EMIF.
- Holds the CPU until calibration completes.
- Converts the valid/ready handshake to Avalon read/write with waitrequest and byteenable.
- Adds a one-line instruction prefetch buffer: burst fills on fetch misses, with a read timeout watchdog.

---
 rtl/picosoc_mem_pkg.sv | 25 ++
 rtl/ddr3_line_buffer.sv | 46 ++++
 rtl/picorv32_ddr3_bridge.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/picosoc_mem_pkg.sv
// Shared types and sizing helpers for the picosoc memory path.
package picosoc_mem_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT,
    IDLE,
    WR_CMD,
    RD_CMD,
    RD_DATA,
    FILL_CMD,
    FILL_DATA,
    RESP
  } bridge_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic int unsigned off_width(int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned tag_width(int unsigned addr_w, int unsigned line_words);
    return addr_w - $clog2(line_words);
  endfunction

endpackage

// File: rtl/ddr3_line_buffer.sv
// Single-line instruction buffer: word storage, tag and valid with hit compare.
module ddr3_line_buffer
  import picosoc_mem_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned OFF_W      = off_width(LINE_WORDS),
  parameter int unsigned TAG_W      = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [OFF_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             fill_done,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             invalidate,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit
);

  logic [31:0]      mem_q [LINE_WORDS];
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (invalidate) begin
      valid_q <= 1'b0;
    end else if (fill_done) begin
      tag_q   <= fill_tag;
      valid_q <= 1'b1;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign hit     = valid_q && (tag_q == lookup_tag);

endmodule

// File: rtl/picorv32_ddr3_bridge.sv
// picorv32 native bus to DDR3 EMIF Avalon-MM bridge with a one-line fetch buffer.
module picorv32_ddr3_bridge
  import picosoc_mem_pkg::*;
#(
  parameter int unsigned AVL_ADDR_W     = 21,
  parameter int unsigned LINE_WORDS     = 8,
  parameter bit          CACHE_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_valid,
  input  logic                        mem_instr,
  output logic                        mem_ready,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_wdata,
  input  logic [3:0]                  mem_wstrb,
  output logic [31:0]                 mem_rdata,
  output logic [AVL_ADDR_W-1:0]       avl_address,
  output logic [31:0]                 avl_writedata,
  output logic [3:0]                  avl_byteenable,
  output logic                        avl_read,
  output logic                        avl_write,
  output logic [$clog2(LINE_WORDS):0] avl_burstcount,
  input  logic                        avl_waitrequest,
  input  logic [31:0]                 avl_readdata,
  input  logic                        avl_readdatavalid,
  input  logic                        init_done,
  output logic                        err,
  output logic [15:0]                 hit_count
);

  localparam int unsigned OFF_W = off_width(LINE_WORDS);
  localparam int unsigned TAG_W = tag_width(AVL_ADDR_W, LINE_WORDS);
  localparam int unsigned BC_W  = OFF_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  bridge_state_e state_q, state_d;

  logic [AVL_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [3:0]            wstrb_q;
  logic [OFF_W-1:0]      off_q, beat_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [15:0]           hit_cnt_q;
  logic                  err_q, skip_q, init_lost_q;

  logic [AVL_ADDR_W-1:0] req_word;
  logic [TAG_W-1:0]      req_tag;
  logic [OFF_W-1:0]      req_off;
  logic                  req_fetch, buf_hit, buf_inv, take_req, is_hit;
  logic                  in_data, beat, tmo_fire, last_beat, cmd_accept;
  logic [31:0]           buf_rdata;
  logic                  unused_addr_bits;

  assign req_word  = mem_addr[AVL_ADDR_W+1:2];
  assign req_tag   = req_word[AVL_ADDR_W-1:OFF_W];
  assign req_off   = req_word[OFF_W-1:0];
  assign req_fetch = mem_instr && CACHE_EN && (mem_wstrb == 4'b0000);
  assign unused_addr_bits = ^{mem_addr[31:AVL_ADDR_W+2], mem_addr[1:0]};

  // Beats are only accepted while a read is outstanding; stragglers are dropped.
  assign in_data    = (state_q == RD_DATA) || (state_q == FILL_DATA);
  assign beat       = in_data && avl_readdatavalid;
  assign tmo_fire   = in_data && !beat && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign last_beat  = beat && (state_q == FILL_DATA) && (beat_q == OFF_W'(LINE_WORDS - 1));
  assign cmd_accept = ((state_q == RD_CMD) || (state_q == FILL_CMD)) && !avl_waitrequest;

  always_comb begin
    state_d  = state_q;
    take_req = 1'b0;
    is_hit   = 1'b0;
    buf_inv  = tmo_fire;
    case (state_q)
      INIT_WAIT: if (init_done) state_d = IDLE;
      IDLE: begin
        if (!init_done) begin
          state_d = INIT_WAIT;
          buf_inv = 1'b1;
        end else if (mem_valid && !skip_q) begin
          take_req = 1'b1;
          if (mem_wstrb != 4'b0000) begin
            state_d = WR_CMD;
            buf_inv = buf_hit;
          end else if (req_fetch && buf_hit) begin
            is_hit  = 1'b1;
            state_d = RESP;
          end else if (req_fetch) begin
            state_d = FILL_CMD;
          end else begin
            state_d = RD_CMD;
          end
        end
      end
      WR_CMD:    if (!avl_waitrequest) state_d = RESP;
      RD_CMD:    if (!avl_waitrequest) state_d = RD_DATA;
      FILL_CMD:  if (!avl_waitrequest) state_d = FILL_DATA;
      RD_DATA:   if (beat || tmo_fire) state_d = RESP;
      FILL_DATA: if (last_beat || tmo_fire) state_d = RESP;
      RESP: begin
        if (!init_done || init_lost_q) begin
          state_d = INIT_WAIT;
          buf_inv = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default:   state_d = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT_WAIT;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      off_q       <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      hit_cnt_q   <= '0;
      err_q       <= 1'b0;
      skip_q      <= 1'b0;
      init_lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= (state_q == RESP);
      if (state_q == INIT_WAIT) init_lost_q <= 1'b0;
      else if (!init_done)      init_lost_q <= 1'b1;
      if (take_req) begin
        addr_q  <= req_fetch ? {req_tag, {OFF_W{1'b0}}} : req_word;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        off_q   <= req_off;
      end
      if (is_hit) begin
        rdata_q   <= buf_rdata;
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (cmd_accept) begin
        tmo_q  <= '0;
        beat_q <= '0;
      end else if (beat) begin
        tmo_q  <= '0;
        beat_q <= beat_q + OFF_W'(1);
        // Requested word is grabbed as it streams past, so no extra read-back cycle.
        if (state_q == RD_DATA || beat_q == off_q) rdata_q <= avl_readdata;
      end else if (in_data) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
      if (tmo_fire) begin
        err_q   <= 1'b1;
        rdata_q <= ERR_DATA;
      end
    end
  end

  ddr3_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .OFF_W      (OFF_W),
    .TAG_W      (TAG_W)
  ) u_line_buffer (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (beat && (state_q == FILL_DATA)),
    .wr_idx     (beat_q),
    .wr_data    (avl_readdata),
    .rd_idx     (req_off),
    .rd_data    (buf_rdata),
    .fill_done  (last_beat && CACHE_EN),
    .fill_tag   (addr_q[AVL_ADDR_W-1:OFF_W]),
    .invalidate (buf_inv),
    .lookup_tag (req_tag),
    .hit        (buf_hit)
  );

  always_comb begin
    avl_write      = (state_q == WR_CMD);
    avl_read       = (state_q == RD_CMD) || (state_q == FILL_CMD);
    avl_address    = (avl_write || avl_read) ? addr_q : '0;
    avl_writedata  = avl_write ? wdata_q : '0;
    avl_byteenable = avl_write ? wstrb_q : '0;
    avl_burstcount = '0;
    if (state_q == FILL_CMD)          avl_burstcount = BC_W'(LINE_WORDS);
    else if (avl_write || avl_read)   avl_burstcount = BC_W'(1);
  end

  assign mem_ready = (state_q == RESP);
  assign mem_rdata = rdata_q;
  assign err       = err_q;
  assign hit_count = hit_cnt_q;

endmodule
